// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, bubble encoding, fetch FSM states and
// the history record used by fetch for load-use replay.
package cpu_defs;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        WAIT_JALR = 2'd1,
        REPLAY    = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } hist_t;

    // Fetch addresses are word aligned; stray low bits are simply dropped.
    function automatic logic [63:0] align4(input logic [63:0] a);
        return a & ~64'h3;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory port: request/address out, same-cycle ready/data back.
interface inst_fetch_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ready, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_ready, output imem_rdata);
endinterface

// File: rtl/jal_imm_gen.sv
// J-type immediate: sign-extended {imm[20],imm[19:12],imm[11],imm[10:1],0}.
module jal_imm_gen (
    input  logic [31:0] i_inst,
    output logic [63:0] o_imm
);
    logic w_unused;

    assign o_imm = {{43{i_inst[31]}}, i_inst[31], i_inst[19:12],
                    i_inst[20], i_inst[30:21], 1'b0};
    // rd and opcode fields carry no immediate bits
    assign w_unused = ^i_inst[11:0];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: same-cycle imem handshake, JAL redirect, JALR wait,
// branch redirect and load-use replay from a two-entry presentation history.
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [31:0] NOP      = NOP_INST
) (
    input  logic         CLK,
    input  logic         reset,
    inst_fetch_if.master imem,
    output logic [31:0]  inst,
    output logic [63:0]  PC_o,
    input  logic         stall,
    input  logic         stall_raise,
    input  logic         jalr_valid,
    input  logic [63:0]  jalr_target,
    input  logic         branch_taken,
    input  logic [63:0]  branch_target
);
    fetch_state_t r_state;
    logic [63:0]  r_pc;
    logic [31:0]  r_inst;
    logic [63:0]  r_pc_o;
    hist_t        r_h1;
    hist_t        r_h0;
    logic         r_run;

    logic         w_req;
    logic         w_hs;
    logic [6:0]   w_opc;
    logic [63:0]  w_jal_off;
    logic [63:0]  w_jal_tgt;

    jal_imm_gen u_jal_imm (
        .i_inst (imem.imem_rdata),
        .o_imm  (w_jal_off)
    );

    // r_run keeps the request low until the first edge after reset release
    assign w_req     = r_run && (r_state == FETCH) && !stall && !stall_raise;
    assign w_hs      = w_req && imem.imem_ready;
    assign w_opc     = imem.imem_rdata[6:0];
    assign w_jal_tgt = align4(r_pc + w_jal_off);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign inst           = r_inst;
    assign PC_o           = r_pc_o;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_inst  <= NOP;
            r_pc_o  <= RESET_PC;
            r_h1    <= {NOP, RESET_PC};
            r_h0    <= {NOP, RESET_PC};
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (branch_taken) begin
                r_pc    <= align4(branch_target);
                r_inst  <= NOP;
                r_h1    <= {NOP, RESET_PC};
                r_h0    <= {NOP, RESET_PC};
                r_state <= FETCH;
            end else if (stall) begin
                r_state <= r_state;
            end else if (stall_raise) begin
                r_inst  <= r_h1.inst;
                r_pc_o  <= r_h1.pc;
                r_state <= REPLAY;
            end else if (r_state == WAIT_JALR) begin
                r_inst <= NOP;
                if (jalr_valid) begin
                    r_pc    <= align4(jalr_target);
                    r_state <= FETCH;
                end
            end else if (r_state == REPLAY) begin
                r_inst  <= r_h0.inst;
                r_pc_o  <= r_h0.pc;
                r_state <= FETCH;
            end else if (w_hs) begin
                r_inst <= imem.imem_rdata;
                r_pc_o <= r_pc;
                r_h1   <= r_h0;
                r_h0   <= {imem.imem_rdata, r_pc};
                // JAL/JALR are still presented so decode can write rd
                if (w_opc == OPC_JAL) begin
                    r_pc <= w_jal_tgt;
                end else if (w_opc == OPC_JALR) begin
                    r_state <= WAIT_JALR;
                end else begin
                    r_pc <= r_pc + 64'd4;
                end
            end else begin
                r_inst <= NOP;
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Table-driven bench for inst_fetch with a scoreboard of accepted fetches.
module tb_inst_fetch;
    import cpu_defs::*;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic [63:0] PC_o;
    logic        stall, stall_raise, jalr_valid, branch_taken;
    logic [63:0] jalr_target, branch_target;

    inst_fetch_if imem_if ();

    inst_fetch dut (
        .CLK           (CLK),
        .reset         (reset),
        .imem          (imem_if),
        .inst          (inst),
        .PC_o          (PC_o),
        .stall         (stall),
        .stall_raise   (stall_raise),
        .jalr_valid    (jalr_valid),
        .jalr_target   (jalr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        sr;
        logic        jv;
        logic [63:0] jt;
        logic        br;
        logic [63:0] bt;
        logic        ereq;
        logic [63:0] eaddr;
        logic [31:0] einst;
        logic [63:0] epc;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] N = 32'h00000013;
    logic [31:0] A, B, C, D, E, JAL16, JALM4, JALR, BEQ, LW;

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'd0, rd, OPC_OPIMM};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic [31:0] rdata, input logic stl,
                       input logic sr, input logic jv, input logic [63:0] jt,
                       input logic br, input logic [63:0] bt, input logic ereq,
                       input logic [63:0] eaddr, input logic [31:0] einst,
                       input logic [63:0] epc);
        vec_t v;
        v.rdy = rdy; v.rdata = rdata; v.stl = stl; v.sr = sr; v.jv = jv; v.jt = jt;
        v.br = br; v.bt = bt; v.ereq = ereq; v.eaddr = eaddr; v.einst = einst; v.epc = epc;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        imem_if.imem_ready = 1'b0;
        imem_if.imem_rdata = 32'h0;
        stall = 1'b0; stall_raise = 1'b0; jalr_valid = 1'b0; branch_taken = 1'b0;
        jalr_target = 64'h0; branch_target = 64'h0;
    endtask

    initial begin
        A = addi(5'd1, 12'd1); B = addi(5'd2, 12'd2); C = addi(5'd3, 12'd3);
        D = addi(5'd4, 12'd4); E = addi(5'd5, 12'd5);
        JAL16 = 32'h010000EF;
        JALM4 = 32'hFFDFF06F;
        JALR  = {12'd0, 5'd5, 3'd0, 5'd1, OPC_JALR};
        BEQ   = {7'd0, 5'd0, 5'd0, 3'd0, 5'd0, OPC_BRANCH};
        LW    = {12'd0, 5'd0, 3'b010, 5'd5, OPC_LOAD};

        //  rdy rdata  stl sr jv jt       br bt                      req addr                     inst   pc
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h0,                   N,     64'h0);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h0,                   A,     64'h0);
        add(1, B,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h4,                   B,     64'h4);
        add(1, C,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h8,                   C,     64'h8);
        add(1, D,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'hC,                   D,     64'hC);
        add(1, E,     0, 0, 0, 64'h0,  1, 64'h8,                   1, 64'h10,                  N,     64'hC);
        add(1, JAL16, 0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h8,                   JAL16, 64'h8);
        add(1, BEQ,   0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h18,                  BEQ,   64'h18);
        add(1, A,     0, 0, 0, 64'h0,  1, 64'h100,                 1, 64'h1C,                  N,     64'h18);
        add(1, LW,    0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h100,                 LW,    64'h100);
        add(0, A,     0, 0, 0, 64'h0,  1, 64'h10,                  1, 64'h104,                 N,     64'h100);
        add(1, JALR,  0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h10,                  JALR,  64'h10);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h10,                  N,     64'h10);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h10,                  N,     64'h10);
        add(1, A,     0, 0, 1, 64'h42, 0, 64'h0,                   0, 64'h10,                  N,     64'h10);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h40,                  A,     64'h40);
        add(1, B,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h44,                  B,     64'h44);
        add(1, C,     0, 1, 0, 64'h0,  0, 64'h0,                   0, 64'h48,                  A,     64'h40);
        add(1, C,     0, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h48,                  B,     64'h44);
        add(1, C,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h48,                  C,     64'h48);
        for (int i = 0; i < 3; i++)
            add(0, D, 0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h4C,                  N,     64'h48);
        for (int i = 0; i < 2; i++)
            add(1, D, 1, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h4C,                  N,     64'h48);
        add(1, D,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h4C,                  D,     64'h4C);
        add(1, A,     1, 0, 0, 64'h0,  0, 64'h0,                   0, 64'h50,                  D,     64'h4C);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h50,                  A,     64'h50);
        add(0, A,     0, 0, 0, 64'h0,  1, 64'hFFFF_FFFF_FFFF_FFFD, 1, 64'h54,                  N,     64'h50);
        add(1, B,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'hFFFF_FFFF_FFFF_FFFC, B,     64'hFFFF_FFFF_FFFF_FFFC);
        add(1, C,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h0,                   C,     64'h0);
        add(1, JALM4, 0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h4,                   JALM4, 64'h4);
        add(1, A,     0, 0, 0, 64'h0,  0, 64'h0,                   1, 64'h0,                   A,     64'h0);

        drive_idle();
        reset = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req",  {63'd0, imem_if.imem_req}, 64'd0);
        chk("rst_addr", imem_if.imem_addr, 64'h0);
        chk("rst_inst", {32'd0, inst}, {32'd0, N});
        chk("rst_pc",   PC_o, 64'h0);

        @(negedge CLK);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            bit   pushed;
            sb_t  s;
            v = vecs[i];
            if (i != 0) @(negedge CLK);
            imem_if.imem_ready = v.rdy;  imem_if.imem_rdata = v.rdata;
            stall = v.stl; stall_raise = v.sr; jalr_valid = v.jv; jalr_target = v.jt;
            branch_taken = v.br; branch_target = v.bt;
            #1;
            chk($sformatf("v%0d_req", i),  {63'd0, imem_if.imem_req}, {63'd0, v.ereq});
            chk($sformatf("v%0d_addr", i), imem_if.imem_addr, v.eaddr);
            pushed = 1'b0;
            if (v.ereq && v.rdy && !v.br && !v.stl && !v.sr) begin
                s.inst = v.rdata; s.pc = v.eaddr;
                sbq.push_back(s);
                pushed = 1'b1;
            end
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d_inst", i), {32'd0, inst}, {32'd0, v.einst});
            chk($sformatf("v%0d_pc", i),   PC_o, v.epc);
            if (pushed) begin
                s = sbq.pop_front();
                chk($sformatf("sb%0d_inst", i), {32'd0, inst}, {32'd0, s.inst});
                chk($sformatf("sb%0d_pc", i),   PC_o, s.pc);
            end
        end

        // Asynchronous reset mid-request abandons the in-flight fetch.
        @(negedge CLK);
        drive_idle();
        #2;
        chk("pre_areset_req", {63'd0, imem_if.imem_req}, 64'd1);
        reset = 1'b0;
        #1;
        chk("areset_req",  {63'd0, imem_if.imem_req}, 64'd0);
        chk("areset_addr", imem_if.imem_addr, 64'h0);
        chk("areset_inst", {32'd0, inst}, {32'd0, N});
        chk("areset_pc",   PC_o, 64'h0);
        @(negedge CLK);
        reset = 1'b1;
        imem_if.imem_ready = 1'b1; imem_if.imem_rdata = B;
        #1;
        chk("post_rst_req0", {63'd0, imem_if.imem_req}, 64'd0);
        @(posedge CLK);
        #1;
        chk("post_rst_inst0", {32'd0, inst}, {32'd0, N});
        @(negedge CLK);
        #1;
        chk("post_rst_req1",  {63'd0, imem_if.imem_req}, 64'd1);
        chk("post_rst_addr1", imem_if.imem_addr, 64'h0);
        @(posedge CLK);
        #1;
        chk("post_rst_inst1", {32'd0, inst}, {32'd0, B});
        chk("post_rst_pc1",   PC_o, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
